// File: rtl/input_conditioner.sv
// Input conditioner: two-flop synchronizers and per-bit debounce for buttons and
// switches, with press/release/long-press pulses and a switch-change strobe.
module input_conditioner #(
    parameter int NB_BTN          = 4,
    parameter int NB_SW           = 4,
    parameter int NB_DEBOUNCE     = 20,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NB_LONG         = 28,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    input  logic [NB_SW-1:0]  i_sw,
    output logic [NB_BTN-1:0] o_btn,
    output logic [NB_BTN-1:0] o_btn_press,
    output logic [NB_BTN-1:0] o_btn_release,
    output logic [NB_BTN-1:0] o_btn_long,
    output logic [NB_SW-1:0]  o_sw,
    output logic              o_sw_change
);

    localparam int NB_ALL = NB_BTN + NB_SW;

    localparam logic [NB_DEBOUNCE-1:0] DEB_LAST  = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB_LONG-1:0]     LONG_LAST = NB_LONG'(LONG_CYCLES - 1);
    localparam logic [NB_LONG-1:0]     LONG_PRE  = (LONG_CYCLES > 1) ? NB_LONG'(LONG_CYCLES - 2) : '0;

    logic [NB_ALL-1:0]      raw;
    logic [NB_ALL-1:0]      sync_meta;
    logic [NB_ALL-1:0]      sync_s;
    logic [NB_ALL-1:0]      q;
    logic [NB_ALL-1:0]      accept;
    logic [NB_DEBOUNCE-1:0] deb_cnt  [NB_ALL];
    logic [NB_DEBOUNCE-1:0] deb_next [NB_ALL];

    logic [NB_LONG-1:0]     long_cnt  [NB_BTN];
    logic [NB_LONG-1:0]     long_next [NB_BTN];
    logic [NB_BTN-1:0]      long_hit;

    logic [NB_BTN-1:0]      btn_press_r;
    logic [NB_BTN-1:0]      btn_release_r;
    logic [NB_BTN-1:0]      btn_long_r;
    logic                   sw_change_r;

    // Buttons occupy the low bits and switches the high bits of every shared vector.
    assign raw = {i_sw, i_btn};

    always_ff @(posedge clock) begin
        if (i_reset) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= raw;
            sync_s    <= sync_meta;
        end
    end

    // A bit is accepted once its synchronized value has disagreed with q for
    // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NB_ALL; i++) begin
            deb_next[i] = '0;
            if (sync_s[i] != q[i]) begin
                if (deb_cnt[i] == DEB_LAST) begin
                    accept[i] = 1'b1;
                end else begin
                    deb_next[i] = deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // The long counter saturates at LONG_LAST so a held button fires only once.
    always_comb begin
        long_hit = '0;
        for (int b = 0; b < NB_BTN; b++) begin
            long_next[b] = '0;
            if (LONG_CYCLES == 1) begin
                long_hit[b] = accept[b] & sync_s[b];
            end
            if (q[b]) begin
                if (long_cnt[b] != LONG_LAST) begin
                    long_next[b] = long_cnt[b] + 1'b1;
                    if ((LONG_CYCLES > 1) && (long_cnt[b] == LONG_PRE)) begin
                        long_hit[b] = 1'b1;
                    end
                end else begin
                    long_next[b] = long_cnt[b];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            q <= '0;
            for (int i = 0; i < NB_ALL; i++) begin
                deb_cnt[i] <= '0;
            end
            for (int b = 0; b < NB_BTN; b++) begin
                long_cnt[b] <= '0;
            end
            btn_press_r   <= '0;
            btn_release_r <= '0;
            btn_long_r    <= '0;
            sw_change_r   <= 1'b0;
        end else begin
            q <= q ^ accept;
            for (int i = 0; i < NB_ALL; i++) begin
                deb_cnt[i] <= deb_next[i];
            end
            for (int b = 0; b < NB_BTN; b++) begin
                long_cnt[b] <= long_next[b];
            end
            btn_press_r   <= accept[NB_BTN-1:0] & sync_s[NB_BTN-1:0];
            btn_release_r <= accept[NB_BTN-1:0] & ~sync_s[NB_BTN-1:0];
            btn_long_r    <= long_hit;
            sw_change_r   <= |accept[NB_ALL-1:NB_BTN];
        end
    end

    assign o_btn         = q[NB_BTN-1:0];
    assign o_sw          = q[NB_ALL-1:NB_BTN];
    assign o_btn_press   = btn_press_r;
    assign o_btn_release = btn_release_r;
    assign o_btn_long    = btn_long_r;
    assign o_sw_change   = sw_change_r;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NB_BTN, 4: number of push-button inputs.
- NB_SW, 4: number of slide-switch inputs.
- NB_DEBOUNCE, 20: width of each debounce counter.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a new level; legal range 1..2^NB_DEBOUNCE-1.
- NB_LONG, 28: width of each long-press counter.
- LONG_CYCLES, 100000000: cycles a debounced button must stay high before o_btn_long fires; legal range 1..2^NB_LONG-1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, input, 1: single clock; all state changes on its rising edge.
- i_reset, input, 1: synchronous reset, active-high.
- i_btn, input, NB_BTN: raw asynchronous button levels.
- i_sw, input, NB_SW: raw asynchronous switch levels.
- o_btn, output, NB_BTN: debounced button levels.
- o_btn_press, output, NB_BTN: one-cycle pulse per debounced 0->1 button transition.
- o_btn_release, output, NB_BTN: one-cycle pulse per debounced 1->0 button transition.
- o_btn_long, output, NB_BTN: one-cycle pulse per long press.
- o_sw, output, NB_SW: debounced switch levels.
- o_sw_change, output, 1: one-cycle pulse when any bit of o_sw changes.

Function
REQ-003 Each button bit and each switch bit SHALL pass through its own two-flop synchronizer; the synchronized value is s, the accepted value is q (q drives o_btn/o_sw).
REQ-004 Per bit, on every clock edge: if s == q, the counter clears; otherwise, if the counter equals DEBOUNCE_CYCLES-1, q <= s and the counter clears; otherwise the counter increments.
REQ-005 Latency: when a raw input changes before edge 0 and stays stable, q SHALL update on edge DEBOUNCE_CYCLES+1; any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave q unchanged.
REQ-006 Pulses on o_btn_press/o_btn_release SHALL be registered and asserted on the same edge q changes, high for exactly one cycle.
REQ-007 Bits are independent; simultaneous events on several bits SHALL produce simultaneous pulses on the corresponding bits.
REQ-008 Each button's long counter SHALL clear while q == 0 and increment while q == 1; on reaching LONG_CYCLES-1, o_btn_long pulses for one cycle and the counter saturates (no further pulse) until q returns to 0.
REQ-009 o_btn_release SHALL pulse normally after a long press; o_btn_press SHALL never coincide with o_btn_long on the same bit unless LONG_CYCLES == 1.
REQ-010 o_sw_change SHALL be registered and asserted on the edge where one or more o_sw bits change.
REQ-011 Counters SHALL never wrap; the DEBOUNCE_CYCLES and LONG_CYCLES limits bound them.

Reset
REQ-012 While i_reset is high at a clock edge, all synchronizer flops, q registers, counters and pulse outputs SHALL be 0; thus every output reads 0 on the cycle after reset.
REQ-013 Reset asserted mid-debounce or mid-long-press SHALL discard the partial count; no pulse from pre-reset activity may appear afterwards.
REQ-014 A button held high through reset release SHALL be treated as a new 0->1 event: o_btn_press pulses on post-reset edge DEBOUNCE_CYCLES+1.

Verification (bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-015 Clean press: i_btn[0] 0->1 before edge 0, held -> o_btn[0]=1 and o_btn_press[0]=1 at edge 5; press low at edge 6; no other bit pulses.
REQ-016 Bounce: i_btn[1] toggles 1,0,1,0 on successive cycles, then holds 1 -> no output change during the toggling; one press pulse 5 edges after the final rising transition.
REQ-017 Long press: i_btn[2] held high 40 cycles then released -> o_btn_long[2] pulses exactly once, 15 edges after the press pulse; o_btn_release[2] pulses 5 edges after release.
REQ-018 Switches: i_sw 4'b0000 -> 4'b1010 -> o_sw=4'b1010 and o_sw_change=1 for one cycle at edge 5; a 2-cycle glitch on i_sw[0] -> o_sw and o_sw_change unchanged.
REQ-019 Reset mid-operation: assert i_reset at count 2 of a press with i_btn[3] held -> all outputs 0 the next cycle; after release, press pulse at post-reset edge 5; o_btn_long[3] never fires from pre-reset time.
REQ-020 Simultaneous: i_btn 4'b0000 -> 4'b1111 -> o_btn_press=4'b1111 for one cycle at edge 5.
